qe_gen: RTL and testbench
=========================

Name: qe_gen

Overview:
- Quadrature encoder signal generator, the transmit side of the quadrature decoder/counter.
- Drives i/q phase outputs to walk an internal 16-bit position toward a commanded target, one quadrature edge per step at a programmable rate.
- Used to emulate an encoder for loopback test of the decoder and to drive stepper-style quadrature inputs of external parts.
- Count convention matches the decoder: forward = i leads q, one count per edge, 4 counts per full cycle.

Parameters:
WIDTH, 16, position/target width in bits; two's-complement, wraps modulo 2^WIDTH.
DIV_W, 16, width of the rate divider.

Ports:
clk  input  1  clock; all state changes on rising edge.
clr  input  1  reset; synchronous, active-high.
target  input  WIDTH  commanded position.
load  input  1  1-cycle strobe; captures target.
rate  input  DIV_W  clocks between edges minus 1; sampled whenever the timer reloads.
enable  input  1  when 0, freezes timer and outputs.
i  output  1  phase A, registered.
q  output  1  phase B, registered.
pos  output  WIDTH  current emulated position, registered.
busy  output  1  high while pos != captured target (state != IDLE).
done  output  1  1-cycle pulse on arrival at target.

Behaviour:
- Reset (clr=1 at a clk edge): pos=0, target_r=0, i=0, q=0, busy=0, done=0, timer=0, state=IDLE. Takes priority over load/enable and aborts any move mid-operation.
- Phase encoding, a pure function of pos[1:0], held in dedicated flops updated in the same cycle as pos (no combinational glitch):
  - 00 -> i=0 q=0
  - 01 -> i=1 q=0
  - 10 -> i=1 q=1
  - 11 -> i=0 q=1
- Forward: 00->10->11->01 in (i,q) order. Exactly one of i/q toggles per step.
- States: IDLE, WAIT.
- IDLE, load=1:
  - target_r<=target.
  - If target==pos: stay IDLE, no step, no done.
  - Otherwise: state<=WAIT, timer<=rate, busy<=1.
- WAIT, enable=1, timer!=0: timer<=timer-1.
- WAIT, enable=1, timer==0 (step):
  - diff=(target_r-pos) mod 2^WIDTH, read as signed.
  - diff>0 or diff==0x8000 (half range): pos<=pos+1 (forward). diff<0: pos<=pos-1. Shortest path, wraps 0xFFFF<->0x0000.
  - i/q updated for the new pos. timer<=rate.
  - If new pos==target_r: state<=IDLE, busy<=0, done<=1 for one cycle.
- WAIT, enable=0: timer, pos, i, q held. load still accepted.
- load in WAIT (retarget): target_r<=target; timer and cadence are not reset.
  - If new target equals the current pos, the retarget and the step decision are resolved the same cycle: state<=IDLE, busy<=0, no done.
  - Retarget may reverse direction without an extra idle edge.
- Latency: load sampled at edge k. First step at edge k+1+rate, then one step every rate+1 enabled clocks. rate=0 gives one edge per clock.
- done is never asserted in the same cycle as busy rising. done and a new load in the same cycle: load wins for state; done still pulses.
- Minimum i/q edge spacing is rate+1 clocks, so the decoder sees no edge closer than that.

Test Plan:
- Reset: assert clr 2 cycles mid-move (pos=3) -> next cycle pos=0, i=q=0, busy=0, done=0.
- Forward: rate=0, load target=5 from 0 -> pos 1,2,3,4,5 on edges k+1..k+5; (i,q)=10,11,01,00,10; done high exactly one cycle after pos=5; busy low the same cycle.
- Reverse with divider: pos=2, rate=3, target=0xFFFE -> 4 steps 4 clocks apart, pos 1,0,0xFFFF,0xFFFE; (i,q) sequence 10,00,01,11.
- Wrap/half range: pos=0, target=0x8000, rate=0 -> moves forward; check 0x7FFF->0x8000 terminates with done.
- Retarget: rate=1, target=10 loaded, reload target=2 when pos=4 -> direction reverses on next step, pos 3,2, single done pulse; reload target=pos -> busy drops, no done.
- Enable gating: rate=0, move to 6, drop enable for 5 cycles at pos=3 -> pos, i, q, timer frozen; resumes with 4 on first enabled cycle.

Source files
------------

// File: rtl/qe_gen.sv
// Quadrature encoder signal generator: steps an internal position toward a
// commanded target, one i/q edge per step, at a programmable clock divider rate.
module qe_gen #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] target,
    input  logic             load,
    input  logic [DIV_W-1:0] rate,
    input  logic             enable,
    output logic             i,
    output logic             q,
    output logic [WIDTH-1:0] pos,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [WIDTH-1:0] POS_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] HALF_SPAN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DIV_W-1:0] TMR_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic             i_q, i_d;
    logic             q_q, q_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] tgt_eff;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] pos_step;
    logic             step_fwd;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tgt_d    = tgt_q;
        timer_d  = timer_q;
        i_d      = i_q;
        q_d      = q_q;
        done_d   = 1'b0;

        // A load in the same cycle as a step steers that step toward the new target.
        tgt_eff  = load ? target : tgt_q;
        diff     = tgt_eff - pos_q;
        // Half-range distance is ambiguous; resolve it as forward.
        step_fwd = !diff[WIDTH-1] || (diff == HALF_SPAN);
        pos_step = step_fwd ? (pos_q + POS_ONE) : (pos_q - POS_ONE);

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    tgt_d = target;
                    if (target != pos_q) begin
                        state_d = ST_WAIT;
                        timer_d = rate;
                    end
                end
            end
            default: begin
                if (load) begin
                    tgt_d = target;
                end
                if (tgt_eff == pos_q) begin
                    state_d = ST_IDLE;
                end else if (enable) begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TMR_ONE;
                    end else begin
                        pos_d   = pos_step;
                        i_d     = pos_step[0] ^ pos_step[1];
                        q_d     = pos_step[1];
                        timer_d = rate;
                        if (pos_step == tgt_eff) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            timer_q <= '0;
            i_q     <= 1'b0;
            q_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            timer_q <= timer_d;
            i_q     <= i_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign i    = i_q;
    assign q    = q_q;
    assign pos  = pos_q;
    assign busy = (state_q == ST_WAIT);
    assign done = done_q;

endmodule

// File: tb/tb_qe_gen.sv
// Bench for qe_gen: per-cycle reference model feeding a scoreboard queue,
// plus directed checks of the documented step sequences.
module tb_qe_gen;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] target = '0;
    logic        load = 1'b0;
    logic [15:0] rate = '0;
    logic        enable = 1'b1;
    logic        i_w, q_w, busy_w, done_w;
    logic [15:0] pos_w;

    always #5 clk = ~clk;

    qe_gen #(.WIDTH(16), .DIV_W(16)) dut (
        .clk(clk), .clr(clr), .target(target), .load(load), .rate(rate),
        .enable(enable), .i(i_w), .q(q_w), .pos(pos_w), .busy(busy_w), .done(done_w)
    );

    typedef struct {
        logic [15:0] pos;
        logic        i, q, busy, done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state; (i,q) taken from a lookup of pos mod 4.
    int   m_pos = 0, m_tgt = 0, m_timer = 0;
    bit   m_busy = 0, m_done = 0;
    logic [1:0] iq_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step();
        int t, d;
        if (clr) begin
            m_pos = 0; m_tgt = 0; m_timer = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (load) begin
                    m_tgt = int'(target);
                    if (int'(target) != m_pos) begin
                        m_busy = 1; m_timer = int'(rate);
                    end
                end
            end else begin
                t = load ? int'(target) : m_tgt;
                if (load) m_tgt = int'(target);
                if (t == m_pos) m_busy = 0;
                else if (enable) begin
                    if (m_timer > 0) m_timer--;
                    else begin
                        d = (t - m_pos) & 32'hFFFF;
                        m_pos = (d <= 32768) ? ((m_pos + 1) & 32'hFFFF) : ((m_pos + 65535) & 32'hFFFF);
                        m_timer = int'(rate);
                        if (m_pos == t) begin m_busy = 0; m_done = 1; end
                    end
                end
            end
        end
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic cycle();
        exp_t e, g;
        model_step();
        e.pos = m_pos[15:0];
        e.i = iq_tab[m_pos[1:0]][1];
        e.q = iq_tab[m_pos[1:0]][0];
        e.busy = m_busy;
        e.done = m_done;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check("sb_pos", pos_w, g.pos);
        check("sb_i", i_w, g.i);
        check("sb_q", q_w, g.q);
        check("sb_busy", busy_w, g.busy);
        check("sb_done", done_w, g.done);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic start_move(input logic [15:0] tgt, input logic [15:0] rt);
        $display("load target=%04h rate=%0d from pos=%04h", tgt, rt, m_pos[15:0]);
        target = tgt; rate = rt; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    logic [1:0] fwd_iq [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    logic [1:0] rev_iq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [15:0] rev_pos [4] = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};

    initial begin
        // Reset, then reset again in the middle of a move at pos=3
        clr = 1'b1;
        run(2);
        clr = 1'b0;
        check("rst_pos", pos_w, 16'h0);
        start_move(16'd10, 16'd0);
        run(3);
        check("mid_pos", pos_w, 16'd3);
        clr = 1'b1;
        cycle();
        check("clr_pos", pos_w, 16'h0);
        check("clr_iq", {i_w, q_w}, 2'b00);
        check("clr_busy", busy_w, 1'b0);
        check("clr_done", done_w, 1'b0);
        cycle();
        clr = 1'b0;

        // Forward 0 -> 5 at one edge per clock
        start_move(16'd5, 16'd0);
        check("fwd_busy_rise", busy_w, 1'b1);
        check("fwd_no_done", done_w, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("fwd_pos", pos_w, k + 1);
            check("fwd_iq", {i_w, q_w}, fwd_iq[k]);
        end
        check("fwd_done", done_w, 1'b1);
        check("fwd_busy_fall", busy_w, 1'b0);
        cycle();
        check("fwd_done_pulse", done_w, 1'b0);

        // Reverse through zero with divider rate=3
        start_move(16'd2, 16'd0);
        run(3);
        check("rev_setup", pos_w, 16'd2);
        start_move(16'hFFFE, 16'd3);
        for (int k = 0; k < 4; k++) begin
            run(3);
            check("rev_hold", pos_w, (k == 0) ? 16'd2 : rev_pos[k-1]);
            cycle();
            check("rev_pos", pos_w, rev_pos[k]);
            check("rev_iq", {i_w, q_w}, rev_iq[k]);
        end
        check("rev_done", done_w, 1'b1);

        // Forward across 0xFFFF->0, then half-range target goes forward
        start_move(16'd0, 16'd0);
        run(2);
        check("wrap_pos", pos_w, 16'h0000);
        start_move(16'h8000, 16'd0);
        cycle();
        check("half_dir", pos_w, 16'h0001);
        run(32766);
        check("half_near", pos_w, 16'h7FFF);
        cycle();
        check("half_pos", pos_w, 16'h8000);
        check("half_done", done_w, 1'b1);

        // Retarget mid-move reverses direction
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        start_move(16'd10, 16'd1);
        run(8);
        check("rt_pos4", pos_w, 16'd4);
        start_move(16'd2, 16'd1);
        check("rt_hold", pos_w, 16'd4);
        cycle();
        check("rt_pos3", pos_w, 16'd3);
        run(2);
        check("rt_pos2", pos_w, 16'd2);
        check("rt_done", done_w, 1'b1);
        cycle();
        check("rt_single_done", done_w, 1'b0);
        start_move(16'd20, 16'd1);
        run(2);
        check("rt_eq_setup", pos_w, 16'd3);
        start_move(16'd3, 16'd1);
        check("rt_eq_busy", busy_w, 1'b0);
        check("rt_eq_done", done_w, 1'b0);

        // Enable gating freezes a move at pos=3
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        start_move(16'd6, 16'd0);
        run(3);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("en_pos", pos_w, 16'd3);
            check("en_iq", {i_w, q_w}, 2'b01);
        end
        enable = 1'b1;
        cycle();
        check("en_resume", pos_w, 16'd4);
        run(2);
        check("en_done", done_w, 1'b1);

        // Randomised loads, rates and enable gating against the model
        for (int k = 0; k < 300; k++) begin
            enable = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) begin
                target = 16'((m_pos + int'($urandom_range(0, 20)) - 10) & 32'hFFFF);
                rate = 16'($urandom_range(0, 3));
                load = 1'b1;
                $display("rand load target=%04h rate=%0d pos=%04h", target, rate, m_pos[15:0]);
            end else begin
                load = 1'b0;
            end
            cycle();
        end
        load = 1'b0;
        enable = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
